// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the memory controller port between the icache fetch
// path and the dcache MSHR issue path, and routes tagged returns back to the
// requester that owns each accepted tag.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration between the
// two requesters (no starvation counter). When it is undefined, the dcache has
// fixed priority and the icache is forced through after STARVE_LIMIT losses.
module mem_bus_arbiter #(
  parameter int XLEN         = 32,
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      icache2arb_command,
  input  logic [XLEN-1:0] icache2arb_addr,
  input  logic [1:0]      dcache2arb_command,
  input  logic [XLEN-1:0] dcache2arb_addr,
  input  logic [63:0]     dcache2arb_data,
  input  logic [3:0]      mem2arb_response,
  input  logic [3:0]      mem2arb_tag,
  input  logic [63:0]     mem2arb_data,
  output logic [1:0]      arb2mem_command,
  output logic [XLEN-1:0] arb2mem_addr,
  output logic [63:0]     arb2mem_data,
  output logic [3:0]      arb2icache_response,
  output logic [3:0]      arb2dcache_response,
  output logic [3:0]      arb2icache_tag,
  output logic [63:0]     arb2icache_data,
  output logic [3:0]      arb2dcache_tag,
  output logic [63:0]     arb2dcache_data,
  output logic [1:0]      arb_grant
);

  localparam logic [1:0]       BUS_NONE   = 2'd0;
  localparam int               TAG_W      = 4;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  // Registered arbitration state; owner bit 1 = dcache, 0 = icache.
  logic             lock_reg;
  logic             lock_owner_reg;
  logic [CNT_W-1:0] starve_cnt_reg;
`ifdef MEM_ARB_RR_EN
  logic             last_winner_reg;
`endif

  // Owner table: one {valid, owner} pair per memory tag.
  logic tag_valid_reg [NUM_TAGS];
  logic tag_owner_reg [NUM_TAGS];

  logic ireq, dreq;
  logic gnt_i, gnt_d, any_grant, accepted;
  logic ret_hit, ret_owner;

  assign ireq      = (icache2arb_command != BUS_NONE);
  assign dreq      = (dcache2arb_command != BUS_NONE);
  assign any_grant = gnt_i | gnt_d;
  assign accepted  = any_grant && (mem2arb_response != '0);

  // Grant selection: a held lock beats everything, then the fairness rule.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (lock_reg && (lock_owner_reg ? dreq : ireq)) begin
      gnt_d = lock_owner_reg;
      gnt_i = !lock_owner_reg;
    end
`ifdef MEM_ARB_RR_EN
    else if (ireq && dreq) begin
      gnt_d = !last_winner_reg;
      gnt_i = last_winner_reg;
    end
`else
    else if (ireq && (starve_cnt_reg >= STARVE_MAX)) begin
      gnt_i = 1'b1;
    end
`endif
    else if (dreq) begin
      gnt_d = 1'b1;
    end else if (ireq) begin
      gnt_i = 1'b1;
    end
  end

  // Forward the granted request to the controller and steer its response back.
  always_comb begin
    arb2mem_command     = BUS_NONE;
    arb2mem_addr        = '0;
    arb2mem_data        = '0;
    if (gnt_d) begin
      arb2mem_command = dcache2arb_command;
      arb2mem_addr    = dcache2arb_addr;
      arb2mem_data    = dcache2arb_data;
    end else if (gnt_i) begin
      arb2mem_command = icache2arb_command;
      arb2mem_addr    = icache2arb_addr;
    end
    arb2icache_response = gnt_i ? mem2arb_response : '0;
    arb2dcache_response = gnt_d ? mem2arb_response : '0;
    arb_grant           = {gnt_d, gnt_i};
  end

  assign ret_hit   = (mem2arb_tag != '0) && tag_valid_reg[mem2arb_tag];
  assign ret_owner = tag_owner_reg[mem2arb_tag];

  // Route a returning tag to the owner recorded before this cycle's update.
  always_comb begin
    arb2icache_tag  = '0;
    arb2icache_data = '0;
    arb2dcache_tag  = '0;
    arb2dcache_data = '0;
    if (ret_hit) begin
      if (ret_owner) begin
        arb2dcache_tag  = mem2arb_tag;
        arb2dcache_data = mem2arb_data;
      end else begin
        arb2icache_tag  = mem2arb_tag;
        arb2icache_data = mem2arb_data;
      end
    end
  end

  // Lock holds the grant across controller busy cycles; starvation/RR history.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_reg       <= 1'b0;
      lock_owner_reg <= 1'b0;
      starve_cnt_reg <= '0;
`ifdef MEM_ARB_RR_EN
      last_winner_reg <= 1'b0;
`endif
    end else begin
      lock_reg <= any_grant && (mem2arb_response == '0);
      if (any_grant) begin
        lock_owner_reg <= gnt_d;
      end
`ifdef MEM_ARB_RR_EN
      starve_cnt_reg <= '0;
      if (accepted) begin
        last_winner_reg <= gnt_d;
      end
`else
      if (!ireq || (gnt_i && accepted)) begin
        starve_cnt_reg <= '0;
      end else if (!gnt_i && (starve_cnt_reg != CNT_SAT)) begin
        starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
      end
`endif
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAGS; gi++) begin : g_owner
      localparam logic [TAG_W-1:0] IDX = TAG_W'(gi);
      // Allocation after a return to the same tag wins, so it is tested first.
      always_ff @(posedge clock) begin
        if (reset) begin
          tag_valid_reg[gi] <= 1'b0;
          tag_owner_reg[gi] <= 1'b0;
        end else if (accepted && (mem2arb_response == IDX)) begin
          tag_valid_reg[gi] <= 1'b1;
          tag_owner_reg[gi] <= gnt_d;
        end else if (ret_hit && (mem2arb_tag == IDX)) begin
          tag_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vector table, hand sequences for reset and
// starvation, then protocol-respecting random traffic against a reference model.
module tb_mem_bus_arbiter;
  localparam int XLEN = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      icache2arb_command;
  logic [XLEN-1:0] icache2arb_addr;
  logic [1:0]      dcache2arb_command;
  logic [XLEN-1:0] dcache2arb_addr;
  logic [63:0]     dcache2arb_data;
  logic [3:0]      mem2arb_response;
  logic [3:0]      mem2arb_tag;
  logic [63:0]     mem2arb_data;
  logic [1:0]      arb2mem_command;
  logic [XLEN-1:0] arb2mem_addr;
  logic [63:0]     arb2mem_data;
  logic [3:0]      arb2icache_response;
  logic [3:0]      arb2dcache_response;
  logic [3:0]      arb2icache_tag;
  logic [63:0]     arb2icache_data;
  logic [3:0]      arb2dcache_tag;
  logic [63:0]     arb2dcache_data;
  logic [1:0]      arb_grant;

  always #5 clock = ~clock;

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .icache2arb_command(icache2arb_command), .icache2arb_addr(icache2arb_addr),
    .dcache2arb_command(dcache2arb_command), .dcache2arb_addr(dcache2arb_addr),
    .dcache2arb_data(dcache2arb_data),
    .mem2arb_response(mem2arb_response), .mem2arb_tag(mem2arb_tag),
    .mem2arb_data(mem2arb_data),
    .arb2mem_command(arb2mem_command), .arb2mem_addr(arb2mem_addr),
    .arb2mem_data(arb2mem_data),
    .arb2icache_response(arb2icache_response), .arb2dcache_response(arb2dcache_response),
    .arb2icache_tag(arb2icache_tag), .arb2icache_data(arb2icache_data),
    .arb2dcache_tag(arb2dcache_tag), .arb2dcache_data(arb2dcache_data),
    .arb_grant(arb_grant)
  );

  typedef struct {
    logic [1:0]  ic;   logic [31:0] ia;
    logic [1:0]  dc;   logic [31:0] da;  logic [63:0] dd;
    logic [3:0]  resp; logic [3:0]  rtag; logic [63:0] rdata;
    logic [1:0]  e_cmd; logic [31:0] e_addr; logic [63:0] e_data;
    logic [3:0]  e_ir; logic [3:0]  e_dr;
    logic [3:0]  e_it; logic [63:0] e_idat;
    logic [3:0]  e_dt; logic [63:0] e_ddat;
    logic [1:0]  e_gnt;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ic, input logic [31:0] ia, input logic [1:0] dc,
                       input logic [31:0] da, input logic [63:0] dd, input logic [3:0] resp,
                       input logic [3:0] rtag, input logic [63:0] rdata);
    icache2arb_command = ic;  icache2arb_addr = ia;
    dcache2arb_command = dc;  dcache2arb_addr = da;  dcache2arb_data = dd;
    mem2arb_response = resp;  mem2arb_tag = rtag;   mem2arb_data = rdata;
  endtask

  task automatic check_all(input string nm, input logic [1:0] e_cmd, input logic [31:0] e_addr,
                           input logic [63:0] e_data, input logic [3:0] e_ir, input logic [3:0] e_dr,
                           input logic [3:0] e_it, input logic [63:0] e_idat,
                           input logic [3:0] e_dt, input logic [63:0] e_ddat, input logic [1:0] e_gnt);
    check({nm, ".cmd"},   64'(arb2mem_command), 64'(e_cmd));
    check({nm, ".addr"},  64'(arb2mem_addr), 64'(e_addr));
    check({nm, ".data"},  arb2mem_data, e_data);
    check({nm, ".iresp"}, 64'(arb2icache_response), 64'(e_ir));
    check({nm, ".dresp"}, 64'(arb2dcache_response), 64'(e_dr));
    check({nm, ".itag"},  64'(arb2icache_tag), 64'(e_it));
    check({nm, ".idata"}, arb2icache_data, e_idat);
    check({nm, ".dtag"},  64'(arb2dcache_tag), 64'(e_dt));
    check({nm, ".ddata"}, arb2dcache_data, e_ddat);
    check({nm, ".grant"}, 64'(arb_grant), 64'(e_gnt));
  endtask

  task automatic idle_reset();
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Reference model state: who = 0 icache, 1 dcache, -1 nobody.
  bit m_lock;
  int m_lock_who;
  int m_wait;
  int m_last;
  int m_own [16];

  vec_t vecs [17];

  initial begin
    // Directed vectors applied back to back from reset.
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 1, 'h1000, 0, 3, 0, 0,       1, 'h1000, 0, 0, 3, 0, 0, 0, 0, 2};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 3, 64'hDEADBEEF_CAFEF00D,
                 0, 0, 0, 0, 0, 0, 0, 3, 64'hDEADBEEF_CAFEF00D, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 3, 1,            0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{1, 'h2000, 0, 0, 0, 0, 0, 0,       1, 'h2000, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[5]  = '{1, 'h2000, 2, 'h3000, 'h1111, 0, 0, 0, 1, 'h2000, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[6]  = '{1, 'h2000, 2, 'h3000, 'h1111, 0, 0, 0, 1, 'h2000, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[7]  = '{1, 'h2000, 2, 'h3000, 'h1111, 5, 0, 0, 1, 'h2000, 0, 5, 0, 0, 0, 0, 0, 1};
    vecs[8]  = '{0, 0, 2, 'h3000, 'h1111, 6, 0, 0,  2, 'h3000, 'h1111, 0, 6, 0, 0, 0, 0, 2};
    vecs[9]  = '{1, 'h4000, 0, 0, 0, 7, 0, 0,       1, 'h4000, 0, 7, 0, 0, 0, 0, 0, 1};
    vecs[10] = '{0, 0, 1, 'h5000, 0, 7, 7, 'h77,    1, 'h5000, 0, 0, 7, 7, 'h77, 0, 0, 2};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 7, 'h88,         0, 0, 0, 0, 0, 0, 0, 7, 'h88, 0};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 5, 'hA5,         0, 0, 0, 0, 0, 5, 'hA5, 0, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 6, 'hB6,         0, 0, 0, 0, 0, 0, 0, 6, 'hB6, 0};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 9, 'h99,         0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[15] = '{0, 0, 1, 'h6000, 'h5A, 2, 0, 0,    1, 'h6000, 'h5A, 0, 2, 0, 0, 0, 0, 2};
    vecs[16] = '{1, 'h7000, 0, 0, 0, 4, 2, 'h22,    1, 'h7000, 0, 4, 0, 0, 0, 2, 'h22, 1};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].ic, vecs[i].ia, vecs[i].dc, vecs[i].da, vecs[i].dd,
            vecs[i].resp, vecs[i].rtag, vecs[i].rdata);
      #2;
      $display("vec %0d: grant=%b cmd=%0d addr=0x%0h iresp=%0d dresp=%0d itag=%0d dtag=%0d",
               i, arb_grant, arb2mem_command, arb2mem_addr, arb2icache_response,
               arb2dcache_response, arb2icache_tag, arb2dcache_tag);
      check_all($sformatf("vec%0d", i), vecs[i].e_cmd, vecs[i].e_addr, vecs[i].e_data,
                vecs[i].e_ir, vecs[i].e_dr, vecs[i].e_it, vecs[i].e_idat,
                vecs[i].e_dt, vecs[i].e_ddat, vecs[i].e_gnt);
      @(negedge clock);
    end

    // Tag 4 is outstanding for the icache; leave an icache lock pending, then reset.
    drive(1, 'h8000, 0, 0, 0, 0, 0, 0);
    #2;
    $display("rst.a: icache waits, grant=%b", arb_grant);
    check("rst.a.grant", 64'(arb_grant), 64'd1);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #2;
    $display("rst.b: reset cycle, grant=%b", arb_grant);
    check_all("rst.b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    drive(1, 'h8000, 1, 'h9000, 'h9, 3, 4, 'h44);
    #2;
    $display("rst.c: stale tag 4 return, grant=%b itag=%0d dtag=%0d",
             arb_grant, arb2icache_tag, arb2dcache_tag);
    check_all("rst.c", 1, 'h9000, 'h9, 0, 3, 0, 0, 0, 0, 2);

    // Both requesters busy for 20 accepted cycles.
    idle_reset();
    for (int k = 1; k <= 20; k++) begin
      int exp_who;
      drive(1, 'hA000, 1, 'hB000, 0, 4'((k % 15) + 1), 0, 0);
      #2;
`ifdef MEM_ARB_RR_EN
      exp_who = (k % 2 == 1) ? 1 : 0;
`else
      exp_who = (k == 9 || k == 18) ? 0 : 1;
`endif
      $display("starve %0d: grant=%b", k, arb_grant);
      check($sformatf("starve%0d.grant", k), 64'(arb_grant), (exp_who == 1) ? 64'd2 : 64'd1);
      check($sformatf("starve%0d.iresp", k), 64'(arb2icache_response),
            (exp_who == 0) ? 64'((k % 15) + 1) : 64'd0);
      check($sformatf("starve%0d.dresp", k), 64'(arb2dcache_response),
            (exp_who == 1) ? 64'((k % 15) + 1) : 64'd0);
      @(negedge clock);
    end

    // Random traffic against the reference model.
    idle_reset();
    m_lock = 0; m_lock_who = -1; m_wait = 0; m_last = 0;
    for (int t = 0; t < 16; t++) m_own[t] = -1;
    begin
      logic [1:0]  r_ic, r_dc;
      logic [31:0] r_ia, r_da;
      logic [63:0] r_dd;
      r_ic = 0; r_dc = 0; r_ia = 0; r_da = 0; r_dd = 0;
      for (int c = 0; c < 400; c++) begin
        logic [3:0]  resp, rtag;
        logic [63:0] rdata;
        int who;
        bit ireq, dreq, hit;
        logic [1:0]  e_cmd; logic [31:0] e_addr; logic [63:0] e_data;
        logic [3:0]  e_it, e_dt; logic [63:0] e_idat, e_ddat;
        if (r_ic == 0 && $urandom_range(0, 2) == 0) begin
          r_ic = 2'd1;
          r_ia = $urandom & 32'hFFFF_FFF8;
        end
        if (r_dc == 0 && $urandom_range(0, 2) == 0) begin
          r_dc = 2'($urandom_range(1, 2));
          r_da = $urandom & 32'hFFFF_FFF8;
          r_dd = {$urandom, $urandom};
        end
        resp  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        rtag  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        rdata = {$urandom, $urandom};
        drive(r_ic, r_ia, r_dc, r_da, r_dd, resp, rtag, rdata);
        #2;
        ireq = (r_ic != 0);
        dreq = (r_dc != 0);
        who = -1;
        if (m_lock && ((m_lock_who == 0 && ireq) || (m_lock_who == 1 && dreq))) who = m_lock_who;
`ifdef MEM_ARB_RR_EN
        else if (ireq && dreq) who = 1 - m_last;
`else
        else if (ireq && m_wait >= 8) who = 0;
`endif
        else if (dreq) who = 1;
        else if (ireq) who = 0;
        e_cmd  = (who == 1) ? r_dc : (who == 0) ? r_ic : 2'd0;
        e_addr = (who == 1) ? r_da : (who == 0) ? r_ia : 32'd0;
        e_data = (who == 1) ? r_dd : 64'd0;
        hit = (rtag != 0) && (m_own[rtag] >= 0);
        e_it   = (hit && m_own[rtag] == 0) ? rtag : 4'd0;
        e_idat = (hit && m_own[rtag] == 0) ? rdata : 64'd0;
        e_dt   = (hit && m_own[rtag] == 1) ? rtag : 4'd0;
        e_ddat = (hit && m_own[rtag] == 1) ? rdata : 64'd0;
        $display("rnd %0d: ireq=%0d dreq=%0d resp=%0d rtag=%0d -> grant=%b", c, ireq, dreq,
                 resp, rtag, arb_grant);
        check_all($sformatf("rnd%0d", c), e_cmd, e_addr, e_data,
                  (who == 0) ? resp : 4'd0, (who == 1) ? resp : 4'd0,
                  e_it, e_idat, e_dt, e_ddat,
                  (who == 1) ? 2'd2 : (who == 0) ? 2'd1 : 2'd0);
        // Advance the model by the rules, then let requesters retire accepted work.
        m_lock = (who >= 0) && (resp == 0);
        m_lock_who = who;
`ifndef MEM_ARB_RR_EN
        if (!ireq || (who == 0 && resp != 0)) m_wait = 0;
        else if (who != 0 && m_wait < 15) m_wait = m_wait + 1;
`endif
        if (hit) m_own[rtag] = -1;
        if (who >= 0 && resp != 0) begin
          m_own[resp] = who;
          m_last = who;
          if (who == 0) r_ic = 0;
          else r_dc = 0;
        end
        @(negedge clock);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
